operand_stack: RTL and testbench
================================

# operand_stack

Parametrised RPN operand stack for the calculator datapath, generalising the single X→Y copy register into a DEPTH-entry stack of WIDTH-bit operands. Entry 0 is X and entry 1 is Y. The block accepts one command per cycle from the keypad/control FSM and the ALU: push, drop, swap, duplicate, replace-X, binary-op writeback and clear. It tracks occupancy and records overflow and underflow conditions for the display/error logic.

## Interface
- WIDTH, 6, operand width in bits (≥1)
- DEPTH, 4, number of stack entries (≥2)
- clk  input  1  rising-edge clock; the single clock for the block
- reset  input  1  synchronous, active-high reset
- op_valid  input  1  command strobe; op and din are sampled when op_valid=1
- op  input  3  command code (see Operation)
- din  input  WIDTH  operand for ENTER, REPLACE_X and BINOP_WB (ALU result)
- x  output  WIDTH  entry 0 (X), registered
- y  output  WIDTH  entry 1 (Y), registered
- count  output  $clog2(DEPTH+1)  number of valid entries, 0..DEPTH
- empty  output  1  count==0
- full  output  1  count==DEPTH
- ovf  output  1  sticky overflow flag
- unf  output  1  sticky underflow flag
- err  output  1  one-cycle pulse flagging that the previous accepted command overflowed or underflowed

## Operation
- Storage is s[0..DEPTH-1]; x=s[0], y=s[1]. "Shift down" means s[i]<=s[i-1] and "shift up" means s[i]<=s[i+1], with 0 written into s[DEPTH-1].
- Commands act only when op_valid=1. When op_valid=0, all state holds and err=0.
- 000 NOP: no change.
- 001 ENTER: shift down; s[0]<=din; count+1.
  - If count==DEPTH, the old s[DEPTH-1] is discarded and count stays at DEPTH.
  - This case sets ovf and pulses err.
- 010 DROP: shift up; count-1.
  - If count==0: no change to data or count; sets unf; pulses err.
- 011 SWAP: s[0]<=s[1] and s[1]<=s[0].
  - If count<2: no change; sets unf; pulses err.
- 100 DUP: shift down with s[0] kept, so s[1]<=s[0]; count+1.
  - If count==0: no change; sets unf; pulses err.
  - If count==DEPTH: performed, the bottom entry is lost, count stays at DEPTH; sets ovf; pulses err.
- 101 REPLACE_X: s[0]<=din.
  - If count==0, count becomes 1; otherwise count is unchanged. Never an error.
- 110 BINOP_WB: consumes X and Y and pushes the result. s[0]<=din; s[i]<=s[i+1] for i≥1; s[DEPTH-1]<=0; count-1.
  - If count<2: no change; sets unf; pulses err.
- 111 CLEAR: all s<=0, count<=0, ovf<=0, unf<=0. err=0.
- ovf and unf are sticky. Only reset and CLEAR clear them.
- Entries at index ≥count read as whatever was shifted in (0 after reset, CLEAR or shift-up). They are not guaranteed to be meaningful beyond that.
- The width of count is $clog2(DEPTH+1). Increments and decrements saturate at DEPTH and at 0 and never wrap.

## Timing
- Every command completes in one cycle. Results are visible on x, y, count, empty, full, ovf and unf after the clk edge that samples op_valid=1.
- err is registered. It is high for exactly the cycle after the sampling edge, then returns to 0 unless the next command also errs.
- Back-to-back commands are allowed every cycle. There is no handshake and no busy state.
- Reset (synchronous, reset=1 at a rising edge):
  - all s=0, count=0, x=0, y=0
  - empty=1, full=0, ovf=0, unf=0, err=0
- reset has priority over any op_valid in the same cycle. A command presented during reset is dropped.
- empty and full are decoded combinationally from the registered count. They carry no extra latency.

## Test plan
- Reset, then ENTER 5, ENTER 9 with DEPTH=4, WIDTH=6 -> x=9, y=5, count=2, empty=0, err never asserted.
- From an empty stack, ENTER 1,2,3,4 then ENTER 7 -> before the last push count=4 and full=1. After the last push, x=7, y=4, s[3]=2 (the 1 is lost), count=4, ovf=1, and err is high for one cycle.
- With x=9, y=5, count=2: SWAP -> x=5, y=9. Then BINOP_WB din=14 -> x=14, y=0, count=1.
- With count=1: DROP -> count=0, empty=1. Then DROP again -> data unchanged, unf=1, err pulses once. Then SWAP -> unf stays 1, err pulses again.
- With ovf=1, unf=1 and count=3: CLEAR -> count=0, x=0, y=0, ovf=0, unf=0. Then REPLACE_X din=63 -> x=63, count=1.
- Assert reset together with op_valid=1 and ENTER din=12 on a stack with count=2 -> after the edge count=0, x=0 and the push is ignored. Also sweep WIDTH=8 with DEPTH=2 and DEPTH=8 through the same sequences.

Source files
------------

// File: rtl/operand_stack.sv
// RPN operand stack: DEPTH entries of WIDTH bits, X at entry 0 and Y at entry 1.
// One command per cycle; sticky overflow/underflow flags plus a one-cycle err pulse.
module operand_stack #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       op_valid,
  input  logic [2:0]                 op,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           x,
  output logic [WIDTH-1:0]           y,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full,
  output logic                       ovf,
  output logic                       unf,
  output logic                       err
);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

  typedef enum logic [2:0] {
    OP_NOP, OP_ENTER, OP_DROP, OP_SWAP, OP_DUP, OP_REPLACE_X, OP_BINOP_WB, OP_CLEAR
  } op_e;

  logic [DEPTH-1:0][WIDTH-1:0] s_q, s_d, s_dn, s_up;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic                        ovf_q, ovf_d, unf_q, unf_d, err_q, err_d;
  logic                        is_empty, is_full, has_two;

  assign is_empty = (cnt_q == '0);
  assign is_full  = (cnt_q == CNT_MAX);
  assign has_two  = (cnt_q >= CW'(2));

  // s_dn keeps s[0] so DUP can use it directly; ENTER overwrites s[0] afterwards.
  always_comb begin
    s_dn[0]       = s_q[0];
    s_up[DEPTH-1] = '0;
    for (int i = 1; i < DEPTH; i++) s_dn[i] = s_q[i-1];
    for (int i = 0; i < DEPTH-1; i++) s_up[i] = s_q[i+1];
  end

  always_comb begin
    s_d   = s_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    err_d = 1'b0;
    if (op_valid) begin
      case (op_e'(op))
        OP_ENTER: begin
          s_d    = s_dn;
          s_d[0] = din;
          if (is_full) begin
            ovf_d = 1'b1;
            err_d = 1'b1;
          end else cnt_d = cnt_q + CW'(1);
        end
        OP_DROP: begin
          if (is_empty) begin
            unf_d = 1'b1;
            err_d = 1'b1;
          end else begin
            s_d   = s_up;
            cnt_d = cnt_q - CW'(1);
          end
        end
        OP_SWAP: begin
          if (!has_two) begin
            unf_d = 1'b1;
            err_d = 1'b1;
          end else begin
            s_d[0] = s_q[1];
            s_d[1] = s_q[0];
          end
        end
        OP_DUP: begin
          if (is_empty) begin
            unf_d = 1'b1;
            err_d = 1'b1;
          end else begin
            s_d = s_dn;
            if (is_full) begin
              ovf_d = 1'b1;
              err_d = 1'b1;
            end else cnt_d = cnt_q + CW'(1);
          end
        end
        OP_REPLACE_X: begin
          s_d[0] = din;
          if (is_empty) cnt_d = CW'(1);
        end
        OP_BINOP_WB: begin
          if (!has_two) begin
            unf_d = 1'b1;
            err_d = 1'b1;
          end else begin
            // X and Y are consumed: shift up, then the ALU result lands in X.
            s_d    = s_up;
            s_d[0] = din;
            cnt_d  = cnt_q - CW'(1);
          end
        end
        OP_CLEAR: begin
          s_d   = '0;
          cnt_d = '0;
          ovf_d = 1'b0;
          unf_d = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s_q   <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      s_q   <= s_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
      err_q <= err_d;
    end
  end

  assign x     = s_q[0];
  assign y     = s_q[1];
  assign count = cnt_q;
  assign empty = is_empty;
  assign full  = is_full;
  assign ovf   = ovf_q;
  assign unf   = unf_q;
  assign err   = err_q;
endmodule

// File: tb/tb_operand_stack.sv
// Bench for operand_stack: three configurations driven in lockstep, a directed
// vector table on the 6x4 instance, then random commands against a list model.
module tb_operand_stack;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, op_valid;
  logic [2:0] op;
  logic [7:0] din;

  logic [5:0] x0, y0;  logic [2:0] c0;  logic e0, f0, o0, u0, r0;
  logic [7:0] x1, y1;  logic [1:0] c1;  logic e1, f1, o1, u1, r1;
  logic [7:0] x2, y2;  logic [3:0] c2;  logic e2, f2, o2, u2, r2;

  operand_stack #(.WIDTH(6), .DEPTH(4)) u_d4 (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op(op), .din(din[5:0]),
    .x(x0), .y(y0), .count(c0), .empty(e0), .full(f0), .ovf(o0), .unf(u0), .err(r0));
  operand_stack #(.WIDTH(8), .DEPTH(2)) u_d2 (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op(op), .din(din),
    .x(x1), .y(y1), .count(c1), .empty(e1), .full(f1), .ovf(o1), .unf(u1), .err(r1));
  operand_stack #(.WIDTH(8), .DEPTH(8)) u_d8 (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op(op), .din(din),
    .x(x2), .y(y2), .count(c2), .empty(e2), .full(f2), .ovf(o2), .unf(u2), .err(r2));

  localparam int DP [3] = '{4, 2, 8};
  localparam int WD [3] = '{6, 8, 8};

  int ax [3], ay [3], ac [3], ae [3], af [3], ao [3], au [3], ar [3];
  always_comb begin
    ax[0] = 32'(x0); ay[0] = 32'(y0); ac[0] = 32'(c0);
    ae[0] = 32'(e0); af[0] = 32'(f0); ao[0] = 32'(o0); au[0] = 32'(u0); ar[0] = 32'(r0);
    ax[1] = 32'(x1); ay[1] = 32'(y1); ac[1] = 32'(c1);
    ae[1] = 32'(e1); af[1] = 32'(f1); ao[1] = 32'(o1); au[1] = 32'(u1); ar[1] = 32'(r1);
    ax[2] = 32'(x2); ay[2] = 32'(y2); ac[2] = 32'(c2);
    ae[2] = 32'(e2); af[2] = 32'(f2); ao[2] = 32'(o2); au[2] = 32'(u2); ar[2] = 32'(r2);
  end

  // Reference: each stack is a list of DP[k] slots, front = X; removing from the
  // front pulls a 0 in at the back, inserting at the front pushes the last slot out.
  int m [3][8];
  int mc [3], mo [3], mu [3], me [3];

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic ins_front(input int k, input int val);
    for (int i = DP[k]-1; i > 0; i--) m[k][i] = m[k][i-1];
    m[k][0] = val;
  endtask

  task automatic del_front(input int k);
    for (int i = 0; i < DP[k]-1; i++) m[k][i] = m[k][i+1];
    m[k][DP[k]-1] = 0;
  endtask

  task automatic model_reset(input int k);
    for (int i = 0; i < 8; i++) m[k][i] = 0;
    mc[k] = 0; mo[k] = 0; mu[k] = 0; me[k] = 0;
  endtask

  task automatic model_step(input int k, input bit v, input logic [2:0] o, input int d);
    int val, t;
    val = d & ((1 << WD[k]) - 1);
    me[k] = 0;
    if (v) begin
      case (o)
        3'd1: begin
          if (mc[k] == DP[k]) begin mo[k] = 1; me[k] = 1; end else mc[k]++;
          ins_front(k, val);
        end
        3'd2: if (mc[k] == 0) begin mu[k] = 1; me[k] = 1; end
              else begin del_front(k); mc[k]--; end
        3'd3: if (mc[k] < 2) begin mu[k] = 1; me[k] = 1; end
              else begin t = m[k][0]; m[k][0] = m[k][1]; m[k][1] = t; end
        3'd4: if (mc[k] == 0) begin mu[k] = 1; me[k] = 1; end
              else begin
                if (mc[k] == DP[k]) begin mo[k] = 1; me[k] = 1; end else mc[k]++;
                ins_front(k, m[k][0]);
              end
        3'd5: begin m[k][0] = val; if (mc[k] == 0) mc[k] = 1; end
        3'd6: if (mc[k] < 2) begin mu[k] = 1; me[k] = 1; end
              else begin del_front(k); m[k][0] = val; mc[k]--; end
        3'd7: model_reset(k);
        default: ;
      endcase
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("d%0d x", DP[k]), ax[k], m[k][0]);
      chk($sformatf("d%0d y", DP[k]), ay[k], m[k][1]);
      chk($sformatf("d%0d count", DP[k]), ac[k], mc[k]);
      chk($sformatf("d%0d empty", DP[k]), ae[k], int'(mc[k] == 0));
      chk($sformatf("d%0d full", DP[k]), af[k], int'(mc[k] == DP[k]));
      chk($sformatf("d%0d ovf", DP[k]), ao[k], mo[k]);
      chk($sformatf("d%0d unf", DP[k]), au[k], mu[k]);
      chk($sformatf("d%0d err", DP[k]), ar[k], me[k]);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
  task automatic step(input bit rst, input bit v, input logic [2:0] o, input int d);
    reset = rst; op_valid = v; op = o; din = 8'(d);
    for (int k = 0; k < 3; k++) begin
      if (rst) model_reset(k);
      else model_step(k, v, o, d);
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  typedef struct {
    bit v; logic [2:0] op; int din;
    int ex, ey, ec, eo, eu, er;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input bit v, input logic [2:0] o, input int d,
                     input int ex, input int ey, input int ec,
                     input int eo, input int eu, input int er);
    vec_t t;
    t.v = v; t.op = o; t.din = d;
    t.ex = ex; t.ey = ey; t.ec = ec; t.eo = eo; t.eu = eu; t.er = er;
    tbl.push_back(t);
  endtask

  task automatic chk_d4(input string tag, input int ex, input int ey, input int ec,
                        input int eo, input int eu, input int er);
    chk({tag, " x"}, ax[0], ex);
    chk({tag, " y"}, ay[0], ey);
    chk({tag, " count"}, ac[0], ec);
    chk({tag, " empty"}, ae[0], int'(ec == 0));
    chk({tag, " full"}, af[0], int'(ec == 4));
    chk({tag, " ovf"}, ao[0], eo);
    chk({tag, " unf"}, au[0], eu);
    chk({tag, " err"}, ar[0], er);
  endtask

  initial begin
    reset = 1'b1; op_valid = 1'b0; op = 3'd0; din = 8'd0;
    step(1, 0, 3'd0, 0);
    step(1, 0, 3'd0, 0);
    chk_d4("reset", 0, 0, 0, 0, 0, 0);

    //  v op din    x   y  cnt ovf unf err   (6-bit, depth 4)
    add(1, 3'd1,  5,  5,  0, 1, 0, 0, 0);
    add(1, 3'd1,  9,  9,  5, 2, 0, 0, 0);
    add(1, 3'd3,  0,  5,  9, 2, 0, 0, 0);
    add(1, 3'd6, 14, 14,  0, 1, 0, 0, 0);
    add(1, 3'd2,  0,  0,  0, 0, 0, 0, 0);
    add(1, 3'd2,  0,  0,  0, 0, 0, 1, 1);
    add(1, 3'd3,  0,  0,  0, 0, 0, 1, 1);
    add(0, 3'd1, 33,  0,  0, 0, 0, 1, 0);
    add(1, 3'd1,  1,  1,  0, 1, 0, 1, 0);
    add(1, 3'd1,  2,  2,  1, 2, 0, 1, 0);
    add(1, 3'd1,  3,  3,  2, 3, 0, 1, 0);
    add(1, 3'd1,  4,  4,  3, 4, 0, 1, 0);
    add(1, 3'd1,  7,  7,  4, 4, 1, 1, 1);
    add(1, 3'd2,  0,  4,  3, 3, 1, 1, 0);
    add(1, 3'd2,  0,  3,  2, 2, 1, 1, 0);
    add(1, 3'd1,  8,  8,  3, 3, 1, 1, 0);
    add(1, 3'd7,  0,  0,  0, 0, 0, 0, 0);
    add(1, 3'd5, 63, 63,  0, 1, 0, 0, 0);
    add(1, 3'd4,  0, 63, 63, 2, 0, 0, 0);
    add(1, 3'd5, 10, 10, 63, 2, 0, 0, 0);
    add(1, 3'd4,  0, 10, 10, 3, 0, 0, 0);
    add(1, 3'd4,  0, 10, 10, 4, 0, 0, 0);
    add(1, 3'd4,  0, 10, 10, 4, 1, 0, 1);
    add(1, 3'd6, 20, 20, 10, 3, 1, 0, 0);
    add(1, 3'd2,  0, 10, 10, 2, 1, 0, 0);
    add(1, 3'd2,  0, 10,  0, 1, 1, 0, 0);
    add(1, 3'd2,  0,  0,  0, 0, 1, 0, 0);
    add(1, 3'd4,  0,  0,  0, 0, 1, 1, 1);
    add(1, 3'd1, 12, 12,  0, 1, 1, 1, 0);
    add(1, 3'd6, 50, 12,  0, 1, 1, 1, 1);
    add(1, 3'd1,  5,  5, 12, 2, 1, 1, 0);
    add(1, 3'd0,  0,  5, 12, 2, 1, 1, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      step(0, tbl[i].v, tbl[i].op, tbl[i].din);
      chk_d4($sformatf("vec%0d", i), tbl[i].ex, tbl[i].ey, tbl[i].ec,
             tbl[i].eo, tbl[i].eu, tbl[i].er);
    end

    // Reset beats a simultaneous ENTER 12 on a two-deep stack.
    step(1, 1, 3'd1, 12);
    chk_d4("rst_vs_enter", 0, 0, 0, 0, 0, 0);
    step(0, 0, 3'd0, 0);
    chk_d4("post_rst", 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 600; i++) begin
      bit       rst, v;
      logic [2:0] o;
      rst = ($urandom_range(0, 99) < 2);
      v   = ($urandom_range(0, 9) != 0);
      o   = 3'($urandom_range(0, 6));
      if ($urandom_range(0, 24) == 0) o = 3'd7;
      step(rst, v, o, int'($urandom_range(0, 255)));
    end

    reset = 1'b0; op_valid = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
